// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants for the radix-4 multiplier arbiter slice.
//   WIDTH_DEF : default operand width (product is 2*WIDTH_DEF bits)
//   NREQ_DEF  : default number of requesters
//   idw_of()  : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;

    // At least one bit, so a requester index is never zero-width.
    function automatic int idw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/radix4_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// radix4_mult_arbiter_if
// Request/result bus between the multiplier users and the arbiter.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b         : packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid/res_ready : result handshake
//   res_q/res_id        : signed 2*WIDTH product and issuing requester index
// Modports: master = requesters + result consumer, slave = arbiter.
// -----------------------------------------------------------------------------
interface radix4_mult_arbiter_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = idw_of(NREQ)
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*WIDTH-1:0]    res_q;
    logic [IDW-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_q, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_q, res_id
    );

endinterface

// File: rtl/radix4_comb.sv
// -----------------------------------------------------------------------------
// radix4_comb
// Purely combinational signed multiplier using radix-4 (modified Booth)
// recoding. Full-width two's-complement product, never truncated.
//   i_a, i_b : signed WIDTH-bit operands
//   o_q      : signed 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module radix4_comb #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_q
);

    localparam int NDIG = (WIDTH + 1) / 2;  // Booth digits, odd widths rounded up
    localparam int PW   = 2 * WIDTH;

    logic signed [PW-1:0]     w_a_ext;
    logic signed [PW-1:0]     w_a_x2;
    logic signed [2*NDIG-1:0] w_b_sx;
    logic [2*NDIG:0]          w_b_ext;
    logic signed [PW-1:0]     w_pp;
    logic signed [PW-1:0]     w_acc;

    // Sized casts of signed operands sign-extend.
    assign w_a_ext = PW'(i_a);
    assign w_a_x2  = w_a_ext <<< 1;
    assign w_b_sx  = (2*NDIG)'(i_b);
    // Implicit zero below the LSB forms the first Booth triplet.
    assign w_b_ext = {w_b_sx, 1'b0};

    // Sum of partial products taken modulo 2^(2*WIDTH); the true product
    // always fits, so the wrap-around of intermediate sums is harmless.
    always_comb begin
        // NOTE: every variable gets a value before any branch, otherwise a
        // path that skips the assignment infers a latch.
        w_acc = '0;
        w_pp  = '0;
        for (int i = 0; i < NDIG; i++) begin
            case (w_b_ext[2*i +: 3])
                3'b001, 3'b010: w_pp = w_a_ext;
                3'b011:         w_pp = w_a_x2;
                3'b100:         w_pp = -w_a_x2;
                3'b101, 3'b110: w_pp = -w_a_ext;
                default:        w_pp = '0;
            endcase
            w_acc = w_acc + (w_pp <<< (2*i));
        end
    end

    assign o_q = w_acc;

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Searches from the priority pointer, wrapping modulo
// NREQ; the pointer moves past the winner on every grant.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : request vector
//   en           : grant enable (no grant and no pointer move when low)
//   gnt          : one-hot grant, all-zero when disabled or idle
//   gnt_id       : index of the winning requester
// -----------------------------------------------------------------------------
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] r_ptr;
    logic           w_found;
    logic [IDW-1:0] w_idx;

    // (base + k) mod NREQ for base < NREQ and k < NREQ; also valid when
    // NREQ is not a power of two.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_inc(r_ptr, k)]) begin
                w_found = 1'b1;
                w_idx   = wrap_inc(r_ptr, k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && w_found) gnt[w_idx] = 1'b1;
    end

    assign gnt_id = w_idx;

    // NOTE: non-blocking assignments for state so every flop samples the
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_ptr <= '0;
        else if (en && w_found)
            r_ptr <= wrap_inc(w_idx, 1);
    end

endmodule

// File: rtl/radix4_mult_arbiter.sv
// -----------------------------------------------------------------------------
// radix4_mult_arbiter
// Shares one radix4_comb multiplier between NREQ requesters. Two-stage
// pipeline: S1 registers the granted operand pair, S2 registers the product.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : request handshake + operands in, result handshake out
// -----------------------------------------------------------------------------
module radix4_mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = idw_of(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    radix4_mult_arbiter_if.slave bus
);

    logic                      r_s1_valid;
    logic signed [WIDTH-1:0]   r_s1_a;
    logic signed [WIDTH-1:0]   r_s1_b;
    logic [IDW-1:0]            r_s1_id;
    logic                      r_s2_valid;
    logic signed [2*WIDTH-1:0] r_s2_q;
    logic [IDW-1:0]            r_s2_id;

    logic                      w_s2_adv;
    logic                      w_s1_free;
    logic                      w_arb_en;
    logic                      w_xfer;
    logic [NREQ-1:0]           w_gnt;
    logic [IDW-1:0]            w_gnt_id;
    logic signed [2*WIDTH-1:0] w_prod;

    // S1 may refill on the same edge it drains, so req_ready depends on
    // res_ready combinationally; res_valid depends only on S2.
    assign w_s2_adv  = r_s1_valid && (!r_s2_valid || bus.res_ready);
    assign w_s1_free = !r_s1_valid || w_s2_adv;
    assign w_arb_en  = w_s1_free && reset_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id)
    );

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign w_xfer        = |w_gnt;
    assign bus.req_ready = w_gnt;

    radix4_comb #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_q (w_prod)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_q     <= '0;
            r_s2_id    <= '0;
        end else begin
            if (w_xfer)
                r_s1_valid <= 1'b1;
            else if (w_s2_adv)
                r_s1_valid <= 1'b0;

            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_q     <= w_prod;
                r_s2_id    <= r_s1_id;
            end else if (r_s2_valid && bus.res_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // NOTE: the S1 operand registers carry no reset; they are only observed
    // while r_s1_valid is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_s1_a  <= bus.req_a[w_gnt_id*WIDTH +: WIDTH];
            r_s1_b  <= bus.req_b[w_gnt_id*WIDTH +: WIDTH];
            r_s1_id <= w_gnt_id;
        end
    end

    assign bus.res_valid = r_s2_valid;
    assign bus.res_q     = r_s2_q;
    assign bus.res_id    = r_s2_id;

endmodule

// File: tb/tb_radix4_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_radix4_mult_arbiter
// Self-checking bench. The reference model treats the arbiter as a
// two-entry in-order queue: an accepted pair becomes visible two samples
// later, S1 is free while fewer than two items are outstanding or the
// result is being taken, and grants follow a round-robin pointer.
// -----------------------------------------------------------------------------
module tb_radix4_mult_arbiter;
    import mult_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = idw_of(N);

    typedef struct {
        int                      id;
        logic signed [2*W-1:0]   q;
        int                      acc;
    } item_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    radix4_mult_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) mbus ();

    radix4_mult_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mbus)
    );

    int errors = 0;
    int checks = 0;

    item_t                 sb[$];
    int                    mptr;
    int                    cyc;
    int                    rst_seen;
    int                    n_xfer;
    logic [W-1:0]          tv_a[N];
    logic [W-1:0]          tv_b[N];
    logic [N-1:0]          tv_valid;
    logic [N-1:0]          done;
    int                    log_id[$];
    logic signed [2*W-1:0] log_q[$];
    int                    log_cyc[$];

    logic signed [W-1:0]   sgn_a[4]   = '{11, -11, -11, 11};
    logic signed [W-1:0]   sgn_b[4]   = '{21, -21, 21, -21};
    logic signed [2*W-1:0] sgn_exp[4] = '{231, 231, -231, -231};

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(W-1){1'b0}}};
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return '0;
            3:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            mbus.req_a[i*W +: W] = tv_a[i];
            mbus.req_b[i*W +: W] = tv_b[i];
        end
        mbus.req_valid = tv_valid;
    endtask

    // Compare DUT outputs with the model just before the rising edge, then
    // advance the model by what that edge will do.
    task automatic observe();
        logic [N-1:0] exp_rdy;
        logic         s1_free;
        logic         exp_vld;
        int           first;
        item_t        it;
        done = '0;
        if (!reset_n) begin
            check("rst_req_ready", mbus.req_ready, '0);
            if (rst_seen > 0) begin
                check("rst_res_valid", mbus.res_valid, '0);
                check("rst_res_q", mbus.res_q, '0);
                check("rst_res_id", mbus.res_id, '0);
            end
            rst_seen++;
            sb.delete();
            mptr = 0;
        end else begin
            rst_seen = 0;
            first = -1;
            for (int k = 0; k < N; k++)
                if (first < 0 && tv_valid[(mptr + k) % N]) first = (mptr + k) % N;
            s1_free = (sb.size() < 2) || mbus.res_ready;
            exp_rdy = '0;
            if (first >= 0 && s1_free) exp_rdy[first] = 1'b1;
            check("req_ready", mbus.req_ready, exp_rdy);

            exp_vld = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
            check("res_valid", mbus.res_valid, exp_vld);
            if (exp_vld) begin
                check("res_q", mbus.res_q, sb[0].q);
                check("res_id", mbus.res_id, sb[0].id);
            end
            if (mbus.res_valid && mbus.res_ready) begin
                log_id.push_back(int'(mbus.res_id));
                log_q.push_back(mbus.res_q);
                log_cyc.push_back(cyc);
            end
            if (exp_vld && mbus.res_ready) void'(sb.pop_front());

            if (first >= 0 && s1_free) begin
                it.id  = first;
                it.q   = $signed(tv_a[first]) * $signed(tv_b[first]);
                it.acc = cyc;
                sb.push_back(it);
                mptr = (first + 1) % N;
                done[first] = 1'b1;
                n_xfer++;
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        drive();
        #2;
        observe();
        @(negedge clk);
    endtask

    task automatic peek();
        drive();
        #1;
    endtask

    task automatic renew(input bit keep);
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                if (keep) begin
                    tv_a[i] = rand_op();
                    tv_b[i] = rand_op();
                end else begin
                    tv_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        int g = 0;
        mbus.res_ready = 1'b1;
        while ((tv_valid != '0 || sb.size() != 0) && g < 200) begin
            cycle();
            renew(1'b0);
            g++;
        end
        check("drain_done", (g < 200), 1'b1);
    endtask

    task automatic clear_log();
        log_id.delete();
        log_q.delete();
        log_cyc.delete();
    endtask

    initial begin
        int start;
        int g;
        int k;
        logic [2*W-1:0] q0;
        bit have;

        cyc      = 0;
        rst_seen = 1;
        mptr     = 0;
        n_xfer   = 0;
        done     = '0;
        reset_n  = 1'b0;
        mbus.res_ready = 1'b1;
        tv_valid = '1;
        for (int i = 0; i < N; i++) begin
            tv_a[i] = rand_op();
            tv_b[i] = rand_op();
        end
        drive();
        @(negedge clk);

        // Reset held for 3 cycles with every requester valid.
        repeat (3) cycle();
        reset_n = 1'b1;

        // Fairness: first grant to 0, then 8 transfers rotate 0..3 twice.
        clear_log();
        start = n_xfer;
        peek();
        check("first_grant", mbus.req_ready, 4'b0001);
        g = 0;
        while (n_xfer - start < 8 && g < 50) begin
            cycle();
            renew(n_xfer - start < 8);
            g++;
        end
        check("fair_progress", (n_xfer - start >= 8), 1'b1);
        drain();
        for (int i = 0; i < 8; i++)
            check($sformatf("fair_id%0d", i), log_id[i], i % 4);

        // Single request from requester 2.
        clear_log();
        tv_valid = 4'b0100;
        tv_a[2]  = 10;
        tv_b[2]  = 20;
        peek();
        check("single_ready", mbus.req_ready, 4'b0100);
        cycle();
        renew(1'b0);
        peek();
        check("single_lat0", mbus.res_valid, 1'b0);
        cycle();
        peek();
        check("single_lat1", mbus.res_valid, 1'b1);
        check("single_q", mbus.res_q, 200);
        check("single_id", mbus.res_id, 2);
        drain();

        // Signs: four combinations back-to-back from requester 1.
        clear_log();
        k = 0;
        tv_valid[1] = 1'b1;
        tv_a[1] = sgn_a[0];
        tv_b[1] = sgn_b[0];
        g = 0;
        while (k < 4 && g < 50) begin
            cycle();
            if (done[1]) begin
                k++;
                if (k < 4) begin
                    tv_a[1] = sgn_a[k];
                    tv_b[1] = sgn_b[k];
                end else begin
                    tv_valid[1] = 1'b0;
                end
            end
            g++;
        end
        drain();
        for (int i = 0; i < 4; i++)
            check($sformatf("sign_q%0d", i), log_q[i], sgn_exp[i]);
        for (int i = 0; i < 3; i++)
            check($sformatf("sign_gap%0d", i), log_cyc[i+1] - log_cyc[i], 1);

        // Backpressure: 5 stalled cycles accept exactly two requests.
        clear_log();
        start = n_xfer;
        mbus.res_ready = 1'b0;
        tv_valid = '1;
        for (int i = 0; i < N; i++) begin
            tv_a[i] = rand_op();
            tv_b[i] = rand_op();
        end
        have = 1'b0;
        q0   = '0;
        repeat (5) begin
            peek();
            if (mbus.res_valid) begin
                if (!have) begin
                    q0   = mbus.res_q;
                    have = 1'b1;
                end else begin
                    check("bp_stable", mbus.res_q, q0);
                end
            end
            cycle();
            renew(1'b0);
        end
        check("bp_accepted", n_xfer - start, 2);
        peek();
        check("bp_full_ready", mbus.req_ready, '0);
        drain();
        check("bp_delivered", log_id.size(), n_xfer - start);

        // Extreme operands: (-2^31) * (-2^31).
        clear_log();
        tv_valid = 4'b1000;
        tv_a[3]  = 32'h8000_0000;
        tv_b[3]  = 32'h8000_0000;
        drain();
        check("extreme_q", log_q[0], 64'h4000_0000_0000_0000);

        // Reset mid-operation discards in-flight work.
        clear_log();
        mbus.res_ready = 1'b0;
        tv_valid = 4'b0011;
        repeat (3) begin
            cycle();
            renew(1'b0);
        end
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        mbus.res_ready = 1'b1;
        peek();
        check("post_rst_idle", mbus.res_valid, 1'b0);
        drain();
        check("rst_discard", log_id.size(), 0);
        tv_valid = 4'b0110;
        tv_a[1] = rand_op(); tv_b[1] = rand_op();
        tv_a[2] = rand_op(); tv_b[2] = rand_op();
        peek();
        check("post_rst_grant", mbus.req_ready, 4'b0010);
        drain();

        // Random traffic: 1000 transfers with random res_ready.
        start = n_xfer;
        g = 0;
        while (n_xfer - start < 1000 && g < 20000) begin
            mbus.res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!tv_valid[i] && $urandom_range(0, 1) == 1) begin
                    tv_valid[i] = 1'b1;
                    tv_a[i] = rand_op();
                    tv_b[i] = rand_op();
                end
            end
            cycle();
            renew(1'b0);
            g++;
        end
        check("rand_progress", (n_xfer - start >= 1000), 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radix4_mult_arbiter.md
# radix4_mult_arbiter

Round-robin scheduler that shares one `radix4_comb` signed multiplier between `NREQ` requesters. It accepts one operand pair per cycle from the highest-priority valid requester and registers it ahead of the combinational multiplier. The product is registered behind the multiplier and returned with the requester index under a valid/ready handshake. It sits between the multiplier users and the single multiplier instance.

## Interface
- `WIDTH`, 32: operand width; the product is `2*WIDTH` bits.
- `NREQ`, 4: number of requesters, at least 2.
- `IDW`, `$clog2(NREQ)`: width of the requester index.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester accept; at most one bit high per cycle.
- `req_a` in `NREQ*WIDTH`: signed operand a; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `req_b` in `NREQ*WIDTH`: signed operand b, sliced the same way.
- `res_valid` out 1: the product is valid.
- `res_ready` in 1: the consumer accepts the product.
- `res_q` out `2*WIDTH`: signed product a*b.
- `res_id` out `IDW`: index of the requester that issued the product.

## Operation
- Pipeline of two stages:
  - S1 is the operand register: `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - S2 is the result register: `s2_valid`, `s2_q`, `s2_id`.
- `radix4_comb` sits between S1 and S2, driven from `s1_a`/`s1_b`.
- Advance conditions:
  - `s2_adv = s1_valid && (!s2_valid || res_ready)`.
  - `s1_free = !s1_valid || s2_adv`.
- Grant:
  - Search starts at `ptr` and wraps modulo `NREQ`.
  - The first index i with `req_valid[i]` is granted, but only if `s1_free`.
  - `req_ready[i] = 1` is combinational from `req_valid`, `ptr` and `s1_free`.
  - Transfer occurs when `req_valid[i] && req_ready[i]`.
- Pointer:
  - On a transfer to i, `ptr <= (i+1) mod NREQ`.
  - With no transfer, `ptr` holds.
  - Wrap: a grant to `NREQ-1` sets `ptr` to 0.
- Result:
  - On `s2_adv`: `s2_q <= signed product`, `s2_id <= s1_id`, `s2_valid <= 1`.
  - Otherwise, on `res_valid && res_ready`: `s2_valid <= 0`.
- S1 update:
  - On transfer: S1 loads the operands and `s1_valid <= 1`.
  - Else if `s2_adv`: `s1_valid <= 0`.
- Outputs: `res_valid = s2_valid`, `res_q = s2_q`, `res_id = s2_id`.
- Arithmetic: both operands are two's complement and the product is the full `2*WIDTH`-bit signed result, never truncated.
  - Example: (-2^(W-1)) * (-2^(W-1)) = 2^(2W-2).
- Requester obligation: a requester must hold `req_a`/`req_b`/`req_valid` stable until it is accepted. The arbiter never drops or duplicates a request.

## Timing
- Reset (`reset_n` low at a clock edge):
  - Cleared: `s1_valid`, `s2_valid`, `ptr`; so `res_valid = 0`, `res_q = 0`, `res_id = 0`.
  - `req_ready` is forced to 0 during reset.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no output. The first grant after reset goes to the lowest valid index.
- Latency: a transfer at edge N gives `res_valid = 1` after edge N+1, with no backpressure.
- Throughput: one product per cycle while `res_ready = 1`.
- Full: with S1 and S2 both valid and `res_ready = 0`, `req_ready` is all-zero.
- Full drain: if `res_ready` rises while full, on the same edge:
  - S2 drains and takes S1;
  - S1 accepts a new request.
- Simultaneous events: with all requesters valid and no stall, grants rotate 0,1,2,3,0,…
- No combinational path from `res_ready` to `res_valid`. A path from `res_ready` to `req_ready` is permitted.

## Structure
- Shared package `mult_pkg`: the default `WIDTH`/`NREQ` constants and a function computing `IDW`.
- Sub-module `rr_arbiter` (`NREQ` parameter):
  - Inputs: `clk`, `reset_n`, `req`, `en`.
  - Outputs: one-hot `gnt` and the index `gnt_id`.
  - It owns `ptr`.
- The top instantiates `rr_arbiter` and `radix4_comb #(.WIDTH(WIDTH))` and holds S1/S2.

## Test plan
- Reset: hold `reset_n` low 3 cycles with all `req_valid` high. Required: `req_ready` = 0, `res_valid` = 0, and the first grant after release goes to index 0.
- Single request: requester 2 sends a=10, b=20. Required: `res_valid` one edge after the transfer edge, with `res_q` = 200 and `res_id` = 2.
- Signs: the four sign combinations of ±11 × ±21 are sent back-to-back. Required: 231, 231, -231 and -231, in order, on consecutive cycles.
- Fairness: all 4 requesters are held valid with `res_ready` = 1 for 8 transfers. Required: `res_id` sequence 0,1,2,3,0,1,2,3.
- Backpressure: hold `res_ready` = 0 for 5 cycles while requesting. Required:
  - exactly 2 requests are accepted, then `req_ready` = 0;
  - `res_q` is stable throughout;
  - after release, results are delivered in order and none are lost.
- Extremes: WIDTH=32, a = b = -2^31. Required: `res_q` = 0x4000_0000_0000_0000. Also run 1000 random operand pairs against a signed scoreboard with random `res_ready`.
